turbo_interleave_ctrl: RTL
==========================

Name: turbo_interleave_ctrl

Overview:
- Control FSM directly upstream of the turbo interleaver buffer stage. It sequences one code block through that stage's reorder RAM in two phases.
- Write phase: accepts CRC-attached bits from the CRC stage and drives `data_valid_FSM` high with a linear `count`, so the buffer writes bit n at address n.
- Read phase: drops `data_valid_FSM` and walks `count` linearly. It drives `address_ROM = {K, count}` so the pi ROM supplies the permuted read address, and flags when `c_prime` out of the buffer is valid.

Parameters:
- LEN0, 1056, block length when K=0
- LEN1, 6144, block length when K=1
- RD_LAT, 2, cycles from `address_ROM` issue to valid `c_prime` (ROM 1 cycle + RAM 1 cycle)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted
- start  in  1  one-cycle pulse: begin a new block; K sampled on this cycle
- K  in  1  block size select (0 → LEN0, 1 → LEN1)
- c_valid  in  1  input bit strobe from the CRC stage (bit itself goes straight to the buffer)
- data_valid_FSM  out  1  1 = buffer write phase (write enable; address = count)
- count  out  13  linear bit index for the current phase
- address_ROM  out  14  {K_lat, count} to the pi ROM
- length  out  13  latched block length for the current block
- c_prime_valid  out  1  c_prime from the buffer is valid this cycle
- busy  out  1  block in progress (LOAD or DRAIN or FLUSH)
- block_done  out  1  one-cycle pulse after the last valid c_prime

Behaviour:
- Reset (reset=0, async) sets:
  - state=IDLE
  - count=0, data_valid_FSM=0, K_lat=0, length=LEN0
  - c_prime_valid=0, busy=0, block_done=0
  - valid pipeline cleared
- Reset mid-block aborts immediately; nothing more is emitted for that block.
- States: IDLE, LOAD, DRAIN, FLUSH.
- IDLE:
  - On start=1: latch K_lat=K and length=(K ? LEN1 : LEN0); set count=0 and data_valid_FSM=1; go to LOAD (registered, visible next cycle).
  - start is ignored in every other state.
- LOAD:
  - data_valid_FSM=1.
  - On c_valid=1 with count<length-1: count increments.
  - On c_valid=1 with count==length-1: count←0, data_valid_FSM←0, go to DRAIN.
  - c_valid=0 holds count (stall). No timeout.
- DRAIN:
  - data_valid_FSM=0.
  - count increments every cycle from 0 to length-1; address_ROM={K_lat,count} combinational from registers.
  - At count==length-1: go to FLUSH, count←0.
- Valid pipeline:
  - A RD_LAT-deep shift register loaded with (state==DRAIN) each cycle.
  - c_prime_valid = its last stage, so c_prime_valid rises exactly RD_LAT cycles after the first DRAIN cycle and stays high for exactly `length` cycles.
- FLUSH:
  - Waits until the valid pipeline is empty, then pulses block_done for 1 cycle and goes to IDLE.
  - A start on the block_done cycle is ignored; the earliest accepted start is the following cycle.
- busy=1 in LOAD, DRAIN, FLUSH.
- Width rules: count and length are 13-bit unsigned; LEN1-1=6143 fits. Wrap to 0 happens only via the length compare, never by overflow.
- c_valid outside LOAD is ignored; the FSM never writes outside LOAD.

Decomposition:
- Shared package holds:
  - LEN0, LEN1, RD_LAT
  - state encoding (3-bit, matching the existing current_state/next_state width)
  - ROM address width 14, count width 13
- One sub-module: valid_delay_line (RD_LAT-deep 1-bit shift register with async active-low clear).

Test Plan:
- Reset → all outputs 0 and length=1056. Assert reset mid-DRAIN at count=500 → next cycle state=IDLE, c_prime_valid=0, no block_done.
- K=0, start, 1056 consecutive c_valid → data_valid_FSM high for exactly 1056 accepted bits with count 0..1055. DRAIN address_ROM runs 0x0000..0x041F. c_prime_valid high 1056 cycles starting 2 cycles after DRAIN entry. block_done once.
- K=1, start, c_valid toggling 1/0 → count advances only on c_valid=1 over 6144 bits. address_ROM[13]=1 throughout DRAIN, last address 0x37FF.
- start pulsed during LOAD and DRAIN with K flipped → ignored; K_lat and length unchanged.
- Back-to-back blocks: start on the cycle after block_done → second block runs fully. No c_prime_valid overlap or gap miscount (total exactly 2×length).
- c_valid asserted in IDLE and DRAIN → count and data_valid_FSM unaffected.

Source files
------------

// File: rtl/turbo_interleave_ctrl_pkg.sv
// Shared constants, state encoding and ROM address layout for the interleaver control block.
package turbo_interleave_ctrl_pkg;

  localparam int unsigned LEN0    = 1056;
  localparam int unsigned LEN1    = 6144;
  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned CNT_W   = 13;
  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FLUSH = 3'd3
  } state_t;

  // Pi ROM address: block size select on top, linear index below.
  typedef struct packed {
    logic             k;
    logic [CNT_W-1:0] idx;
  } rom_addr_t;

  // Block length for a given size select.
  function automatic logic [CNT_W-1:0] block_len(input logic k);
    return k ? CNT_W'(LEN1) : CNT_W'(LEN0);
  endfunction

endpackage

// File: rtl/turbo_interleave_ctrl_valid_delay_line.sv
// Fixed-depth 1-bit shift register tracking which buffer reads are still in flight.
module turbo_interleave_ctrl_valid_delay_line #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic empty_next_c
);

  logic [DEPTH-1:0] sr;
  logic [DEPTH-1:0] sr_next_c;

  // Shift in at bit 0; the truncation drops the oldest stage.
  assign sr_next_c = DEPTH'({sr, din});

  // Pipeline stages, cleared by reset so an aborted block emits nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= sr_next_c;
  end

  assign dout         = sr[DEPTH-1];
  assign empty_next_c = ~|sr_next_c;

endmodule

// File: rtl/turbo_interleave_ctrl.sv
// Sequences one code block through the interleaver reorder RAM: linear write, then permuted read.
module turbo_interleave_ctrl
  import turbo_interleave_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              K,
  input  logic              c_valid,
  output logic              data_valid_FSM,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] address_ROM,
  output logic [CNT_W-1:0]  length,
  output logic              c_prime_valid,
  output logic              busy,
  output logic              block_done
);

  state_t           state, state_n;
  logic [CNT_W-1:0] count_n, length_n, last_idx_c;
  logic             k_lat, k_lat_n;
  logic             dv_n, busy_n, done_n;
  logic             in_drain_c, line_empty_next_c;
  rom_addr_t        rom_addr_c;

  assign last_idx_c  = CNT_W'(length - CNT_W'(1));
  assign in_drain_c  = (state == ST_DRAIN);
  assign rom_addr_c  = '{k: k_lat, idx: count};
  assign address_ROM = rom_addr_c;

  // Tracks reads issued during DRAIN until their data leaves the buffer.
  turbo_interleave_ctrl_valid_delay_line #(
    .DEPTH (RD_LAT)
  ) u_valid_line (
    .clk          (clk),
    .rst_n        (reset),
    .din          (in_drain_c),
    .dout         (c_prime_valid),
    .empty_next_c (line_empty_next_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      count          <= '0;
      length         <= CNT_W'(LEN0);
      k_lat          <= 1'b0;
      data_valid_FSM <= 1'b0;
      busy           <= 1'b0;
      block_done     <= 1'b0;
    end else begin
      state          <= state_n;
      count          <= count_n;
      length         <= length_n;
      k_lat          <= k_lat_n;
      data_valid_FSM <= dv_n;
      busy           <= busy_n;
      block_done     <= done_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    count_n  = count;
    length_n = length;
    k_lat_n  = k_lat;
    dv_n     = 1'b0;
    done_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          k_lat_n  = K;
          length_n = block_len(K);
          count_n  = '0;
          dv_n     = 1'b1;
          state_n  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dv_n = 1'b1;
        if (c_valid) begin
          if (count == last_idx_c) begin
            count_n = '0;
            dv_n    = 1'b0;
            state_n = ST_DRAIN;
          end else begin
            count_n = CNT_W'(count + CNT_W'(1));
          end
        end
      end
      ST_DRAIN: begin
        if (count == last_idx_c) begin
          count_n = '0;
          state_n = ST_FLUSH;
        end else begin
          count_n = CNT_W'(count + CNT_W'(1));
        end
      end
      ST_FLUSH: begin
        count_n = '0;
        // Hold FLUSH through the done pulse so a start there is not taken.
        if (block_done)             state_n = ST_IDLE;
        else if (line_empty_next_c) done_n  = 1'b1;
      end
      default: begin
        state_n = ST_IDLE;
        count_n = '0;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

endmodule
